// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles little-endian words, writes them to memory,
// then reads the written region back and compares its sum against the write checksum.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] word_count,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_data_in,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_data_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum,
  output logic        verify_ok
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [10:0] LP_MAX = 11'(MAX_WORDS);

  state_t      r_state;
  state_t      w_state_next;
  logic [10:0] r_count;
  logic [10:0] r_word_idx;
  logic [10:0] r_vcnt;
  logic [1:0]  r_byte_idx;
  logic [31:0] r_word;
  logic [31:0] r_wr_addr;
  logic [31:0] r_wr_data;
  logic [31:0] r_rd_addr;
  logic [31:0] r_checksum;
  logic [31:0] r_rsum;
  logic        r_verify_ok;

  logic [10:0] w_count;
  logic [10:0] w_word_idx_inc;
  logic [10:0] w_vcnt_inc;
  logic [31:0] w_word_next;
  logic        w_accept;
  logic        w_last_word;
  logic        w_verify_end;

  assign w_count        = (word_count > LP_MAX) ? LP_MAX : word_count;
  assign w_word_idx_inc = r_word_idx + 11'd1;
  assign w_vcnt_inc     = r_vcnt + 11'd1;
  assign w_accept       = (r_state == S_LOAD) && in_valid;
  assign w_last_word    = (w_word_idx_inc == r_count);
  assign w_verify_end   = (r_vcnt == r_count);

  // Merge the incoming byte into its little-endian lane of the word being built
  always_comb begin
    w_word_next = r_word;
    w_word_next[{r_byte_idx, 3'b000} +: 8] = in_byte;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (w_count == 11'd0) ? S_DONE : S_LOAD;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_accept && (r_byte_idx == 2'd3)) begin
          w_state_next = S_WRITE;
        end else begin
          w_state_next = S_LOAD;
        end
      end
      S_WRITE:  w_state_next = w_last_word ? S_VERIFY : S_LOAD;
      S_VERIFY: w_state_next = w_verify_end ? S_DONE : S_VERIFY;
      S_DONE:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Datapath: word assembly, write/read addressing, checksum and readback sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= 11'd0;
      r_word_idx  <= 11'd0;
      r_vcnt      <= 11'd0;
      r_byte_idx  <= 2'd0;
      r_word      <= 32'd0;
      r_wr_addr   <= 32'd0;
      r_wr_data   <= 32'd0;
      r_rd_addr   <= 32'd0;
      r_checksum  <= 32'd0;
      r_rsum      <= 32'd0;
      r_verify_ok <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count     <= w_count;
            r_word_idx  <= 11'd0;
            r_vcnt      <= 11'd0;
            r_byte_idx  <= 2'd0;
            r_checksum  <= 32'd0;
            r_rsum      <= 32'd0;
            // An empty load has nothing to mismatch, so it reports success directly
            r_verify_ok <= (w_count == 11'd0);
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_word     <= w_word_next;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_wr_addr <= BASE_ADDR + {21'd0, r_word_idx};
              r_wr_data <= w_word_next;
            end
          end
        end
        S_WRITE: begin
          r_checksum <= r_checksum + r_wr_data;
          r_word_idx <= w_word_idx_inc;
          if (w_last_word) begin
            r_rd_addr <= BASE_ADDR;
            r_vcnt    <= 11'd0;
          end
        end
        S_VERIFY: begin
          r_vcnt <= w_vcnt_inc;
          // Read data trails the address by one cycle, so cycle 0 has nothing to sum
          if (r_vcnt != 11'd0) begin
            r_rsum <= r_rsum + mem_data_out;
          end
          if (w_vcnt_inc < r_count) begin
            r_rd_addr <= BASE_ADDR + {21'd0, w_vcnt_inc};
          end
          if (w_verify_end) begin
            r_verify_ok <= ((r_rsum + mem_data_out) == r_checksum);
          end
        end
        S_DONE: begin
          r_vcnt <= r_vcnt;
        end
        default: begin
          r_vcnt <= r_vcnt;
        end
      endcase
    end
  end

  assign in_ready          = (r_state == S_LOAD);
  assign busy              = (r_state != S_IDLE);
  assign done              = (r_state == S_DONE);
  assign mem_write_enable  = (r_state == S_WRITE);
  assign mem_write_address = r_wr_addr;
  assign mem_data_in       = r_wr_data;
  assign mem_read_address  = r_rd_addr;
  assign checksum          = r_checksum;
  assign verify_ok         = r_verify_ok;

endmodule

// File: tb/tb_prog_loader.sv
// Directed/randomized bench for prog_loader with a word memory model and a
// byte-queue reference model of the expected writes, checksum and timing.
module tb_prog_loader;

  localparam logic [31:0] BASE = 32'hFFFF_FFFE;
  localparam int          MAXW = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] word_count = 11'd0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_read_address;
  logic [31:0] mem_data_out;
  logic        busy;
  logic        done;
  logic [31:0] checksum;
  logic        verify_ok;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];
  logic [31:0] wr_a [0:255];
  logic [31:0] wr_d [0:255];
  int          wr_cnt = 0;
  logic [31:0] rd_log [0:2047];
  logic [7:0]  bytes_q [$];
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'd0;

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_data_in(mem_data_in), .mem_read_address(mem_read_address),
    .mem_data_out(mem_data_out), .busy(busy), .done(done),
    .checksum(checksum), .verify_ok(verify_ok)
  );

  always #5 clk = ~clk;

  // Memory model: write port plus one-cycle-latency read port with optional corruption
  always @(posedge clk) begin
    if (mem_write_enable) begin
      mem[mem_write_address[7:0]] <= mem_data_in;
      if (wr_cnt < 256) begin
        wr_a[wr_cnt] <= mem_write_address;
        wr_d[wr_cnt] <= mem_data_in;
      end
      wr_cnt <= wr_cnt + 1;
    end
    mem_data_out <= mem[mem_read_address[7:0]] ^
                    ((corrupt_en && mem_read_address == corrupt_addr) ? 32'h0000_0100 : 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int nbytes);
    bytes_q.delete();
    for (int i = 0; i < nbytes; i++) bytes_q.push_back(8'($urandom));
  endtask

  // Drives one load and checks it against the byte-queue model (unless aborted)
  task automatic run_load(input int n_req, input bit gaps, input int abort_cyc, input int busy_start_cyc);
    int n, wb, ptr, done_cyc;
    bit seen, consumed, exp_ok;
    logic [31:0] rd_before, exp_sum, w, a;
    n = (n_req > MAXW) ? MAXW : n_req;
    wb = wr_cnt;
    rd_before = mem_read_address;
    ptr = 0; seen = 1'b0; done_cyc = 0;
    @(negedge clk);
    start = 1'b1;
    word_count = 11'(n_req);
    @(posedge clk);
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start = (c == busy_start_cyc);
      if (start) word_count = 11'd0;
      if (c == 1) begin
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ready_after_start", {31'd0, in_ready}, (n > 0) ? 32'd1 : 32'd0);
      end
      rd_log[c] = mem_read_address;
      if (done) begin
        seen = 1'b1;
        done_cyc = c;
        break;
      end
      if (c == abort_cyc) begin
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (ptr < 4 * n) begin
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        in_byte = bytes_q[ptr];
      end else begin
        in_valid = 1'b0;
      end
      consumed = in_valid && in_ready;
      @(posedge clk);
      if (consumed) ptr++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (!gaps) chk("done_cycle", done_cyc, (n == 0) ? 32'd1 : 32'(6 * n + 2));
    chk("write_count", wr_cnt - wb, n);
    exp_sum = 32'd0;
    exp_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      w = {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]};
      a = BASE + 32'(i);
      exp_sum = exp_sum + w;
      if (corrupt_en && a == corrupt_addr) exp_ok = 1'b0;
      if (wb + i < 256) begin
        chk("write_addr", wr_a[wb+i], a);
        chk("write_data", wr_d[wb+i], w);
      end
      if (!gaps) chk("read_addr", rd_log[5*n+1+i], a);
    end
    chk("checksum", checksum, exp_sum);
    chk("verify_ok", {31'd0, verify_ok}, {31'd0, exp_ok});
    if (n == 0) chk("no_read_activity", mem_read_address, rd_before);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("checksum_hold", checksum, exp_sum);
  endtask

  initial begin
    int wb_before;
    logic [31:0] word0;

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
    chk("rst_waddr", mem_write_address, 32'd0);
    chk("rst_raddr", mem_read_address, 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    rst = 1'b0;

    // Basic load, then the same bytes with random valid gaps
    bytes_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(2, 1'b0, 0, 0);
    chk("basic_checksum_const", checksum, 32'hF0E2_1567);
    run_load(2, 1'b1, 0, 0);

    // Checksum wrap, then the same load with a corrupted readback of word 1
    bytes_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    run_load(2, 1'b0, 0, 0);
    chk("wrap_checksum_const", checksum, 32'h0000_0001);
    corrupt_en = 1'b1;
    corrupt_addr = BASE + 32'd1;
    run_load(2, 1'b0, 0, 0);
    corrupt_en = 1'b0;

    // Empty load, clamped load with address wrap, random gapped load
    bytes_q.delete();
    run_load(0, 1'b0, 0, 0);
    fill_random(4 * MAXW);
    run_load(9, 1'b0, 0, 0);
    fill_random(16);
    run_load(4, 1'b1, 0, 0);

    // Reset mid-LOAD after two bytes of word 1, with a start pulsed while busy
    fill_random(12);
    word0 = {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]};
    wb_before = wr_cnt;
    run_load(3, 1'b0, 8, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("arst_we", {31'd0, mem_write_enable}, 32'd0);
    chk("arst_wdata", mem_data_in, 32'd0);
    chk("arst_checksum", checksum, 32'd0);
    chk("arst_verify_ok", {31'd0, verify_ok}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("arst_writes", wr_cnt - wb_before, 32'd1);
    chk("arst_word0_addr", wr_a[wb_before], BASE);
    chk("arst_mem_kept", mem[BASE[7:0]], word0);
    rst = 1'b0;
    fill_random(4);
    run_load(1, 1'b0, 0, 0);
    chk("fresh_mem", mem[BASE[7:0]], {bytes_q[3], bytes_q[2], bytes_q[1], bytes_q[0]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
